// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
//   Parametrised LIFO stack for the CPU datapath (call/return addresses,
//   operand stack). The top entry is cached in a register so data_out_o is
//   always registered; the memory holds only the entries beneath the top.
//   Out-of-range operations are rejected and reported through sticky flags.
//
// Parameters
//   DATA_WIDTH  entry width in bits (>= 1)
//   DEPTH       maximum number of entries (>= 2, any value)
//
// Ports
//   clk_i        single clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset, dominates every other input
//   en_i         operation enable; push/pop/clr_err are ignored when low
//   push_i       push data_i (replace when pop_i is also high)
//   pop_i        pop the top entry
//   clr_err_i    clear both sticky error flags
//   data_i       value to push
//   data_out_o   current top of stack, 0 when empty
//   count_o      number of stored entries, 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   overflow_o   sticky: a push was rejected because the stack was full
//   underflow_o  sticky: a pop was rejected because the stack was empty
// -----------------------------------------------------------------------------
module param_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clr_err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [CW-1:0]         count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    // The memory only stores entries below the cached top: DEPTH-1 slots.
    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  mem_we;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  is_empty;
    logic                  is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // With n entries stored, the entries below the top occupy slots 0..n-2.
    // A push spills the old top into slot n-1; a pop refills from slot n-2.
    assign wr_idx = AW'(count_q - CW'(1));
    assign rd_idx = AW'(count_q - CW'(2));

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;

        if (en_i) begin
            // Clear first so an error raised below in the same cycle wins.
            if (clr_err_i) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            if (push_i && !pop_i) begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    top_d   = data_i;
                    count_d = count_q + CW'(1);
                    mem_we  = !is_empty;
                end
            end else if (pop_i && !push_i) begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                    // Forcing zero on the last pop keeps data_out_o == 0
                    // whenever the stack is empty.
                    top_d   = (count_q > CW'(1)) ? mem_q[rd_idx] : '0;
                end
            end else if (push_i && pop_i) begin
                // Replace; on an empty stack this degenerates to a push.
                top_d = data_i;
                if (is_empty) begin
                    count_d = CW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // unreachable until written, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem_q[wr_idx] <= top_q;
        end
    end

    assign data_out_o  = top_q;
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
//   Self-checking bench for param_stack at DATA_WIDTH=8, DEPTH=4. Each
//   directed step drives the inputs on the falling edge and queues the
//   hand-computed outputs expected after the next rising edge; a separate
//   monitor pops and compares one entry per rising edge.
// -----------------------------------------------------------------------------
module tb_param_stack;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    typedef struct {
        string          name;
        logic [CW-1:0]  cnt;
        logic [DW-1:0]  data;
        logic           empty;
        logic           full;
        logic           ovf;
        logic           unf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          en_i = 1'b0;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_out_o;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;
    logic          overflow_o;
    logic          underflow_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    param_stack #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .clr_err_i   (clr_err_i),
        .data_i      (data_i),
        .data_out_o  (data_out_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got cnt/data/e/f/o/u=%h required %h", name, act, req);
        end
    endtask

    // Monitor: one registered output per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name,
                  {1'b0, count_o, data_out_o, empty_o, full_o, overflow_o, underflow_o},
                  {1'b0, e.cnt, e.data, e.empty, e.full, e.ovf, e.unf});
        end
    end

    // Drive one cycle of stimulus and queue its expected outcome.
    // Expected fields: count, data_out, empty, full, overflow, underflow.
    task automatic step(input string name, input logic rst, input logic en,
                        input logic psh, input logic pp, input logic clr,
                        input logic [DW-1:0] din,
                        input int cnt, input logic [DW-1:0] dout,
                        input logic emp, input logic ful,
                        input logic ovf, input logic unf);
        exp_t e;
        @(negedge clk);
        reset_i   = rst;
        en_i      = en;
        push_i    = psh;
        pop_i     = pp;
        clr_err_i = clr;
        data_i    = din;
        e.name  = name;
        e.cnt   = CW'(cnt);
        e.data  = dout;
        e.empty = emp;
        e.full  = ful;
        e.ovf   = ovf;
        e.unf   = unf;
        exp_q.push_back(e);
    endtask

    initial begin
        //    name            rst en ps pp clr din    cnt dout   e  f  o  u
        step("reset",          1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        step("reset_w_push",   1, 1, 1, 0, 0, 8'hEE, 0, 8'h00, 1, 0, 0, 0);
        step("idle_en0_a",     0, 0, 1, 0, 0, 8'h5A, 0, 8'h00, 1, 0, 0, 0);
        step("idle_en0_b",     0, 0, 1, 0, 0, 8'hA5, 0, 8'h00, 1, 0, 0, 0);
        step("idle_en0_pop",   0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

        step("push_11",        0, 1, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 0);
        step("push_22",        0, 1, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 0);
        step("push_33",        0, 1, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0, 0, 0);
        step("push_44_full",   0, 1, 1, 0, 0, 8'h44, 4, 8'h44, 0, 1, 0, 0);
        step("push_55_ovf",    0, 1, 1, 0, 0, 8'h55, 4, 8'h44, 0, 1, 1, 0);
        step("en0_pop_hold",   0, 0, 0, 1, 0, 8'h00, 4, 8'h44, 0, 1, 1, 0);
        step("en0_clr_hold",   0, 0, 0, 0, 1, 8'h00, 4, 8'h44, 0, 1, 1, 0);

        step("pop_to_33",      0, 1, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0, 1, 0);
        step("pop_to_22",      0, 1, 0, 1, 0, 8'h00, 2, 8'h22, 0, 0, 1, 0);
        step("pop_to_11",      0, 1, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0, 1, 0);
        step("pop_to_empty",   0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0);
        step("pop_unf",        0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1);
        step("clr_err",        0, 1, 0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 0);

        step("rp_push_11",     0, 1, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 0);
        step("rp_push_22",     0, 1, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 0);
        step("replace_99",     0, 1, 1, 1, 0, 8'h99, 2, 8'h99, 0, 0, 0, 0);
        step("pop_after_rep",  0, 1, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0, 0, 0);
        step("pop_rp_empty",   0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        step("replace_empty",  0, 1, 1, 1, 0, 8'h07, 1, 8'h07, 0, 0, 0, 0);

        step("pop_07",         0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        step("pop_unf2",       0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1);
        step("fill_11",        0, 1, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 1);
        step("fill_22",        0, 1, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 1);
        step("fill_33",        0, 1, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0, 0, 1);
        step("fill_44",        0, 1, 1, 0, 0, 8'h44, 4, 8'h44, 0, 1, 0, 1);
        step("clr_with_ovf",   0, 1, 1, 0, 1, 8'h55, 4, 8'h44, 0, 1, 1, 0);
        step("replace_full",   0, 1, 1, 1, 0, 8'hAA, 4, 8'hAA, 0, 1, 1, 0);
        step("pop_after_rf",   0, 1, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0, 1, 0);
        step("pop_below_rf",   0, 1, 0, 1, 0, 8'h00, 2, 8'h22, 0, 0, 1, 0);

        step("pre_rst_reset",  1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        step("pre_rst_11",     0, 1, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 0);
        step("pre_rst_22",     0, 1, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 0);
        step("pre_rst_33",     0, 1, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0, 0, 0);
        step("reset_mid_push", 1, 1, 1, 0, 0, 8'h66, 0, 8'h00, 1, 0, 0, 0);
        step("push_ab",        0, 1, 1, 0, 0, 8'hAB, 1, 8'hAB, 0, 0, 0, 0);
        step("pop_ab",         0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

        @(negedge clk);
        en_i   = 1'b0;
        push_i = 1'b0;
        pop_i  = 1'b0;

        // Bounded drain: every queued expectation must have been consumed.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
